// File: rtl/dino_jump.sv
// Dino vertical motion: integer velocity/gravity jump physics, one position step per frame_tick.
// Optional double jump when built with JUMP_DOUBLE_EN; default build ignores airborne presses.
module dino_jump #(
    parameter int GROUND_Y = 106,
    parameter int V0       = 6,
    parameter int GRAVITY  = 1,
    parameter int HEIGHT_W = 16
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                frame_tick,
    input  logic                jump_btn,
    input  logic                active,
    input  logic                kill,
    output logic [HEIGHT_W-1:0] height,
    output logic                airborne,
    output logic                jump_done
);

    typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

`ifdef JUMP_DOUBLE_EN
    localparam bit DoubleEn = 1'b1;
`else
    localparam bit DoubleEn = 1'b0;
`endif

    localparam logic [HEIGHT_W-1:0] GroundH  = HEIGHT_W'(GROUND_Y);
    localparam logic [HEIGHT_W:0]   GroundX  = (HEIGHT_W+1)'(GROUND_Y);
    localparam logic [7:0]          LaunchV  = 8'(V0);
    localparam logic [7:0]          GravV    = 8'(GRAVITY);

    state_t                state_q, state_d;
    logic [HEIGHT_W-1:0]   height_q, height_d;
    logic [7:0]            vel_q, vel_d;
    logic                  dj_used_q, dj_used_d;
    logic                  done_q, done_d;
    logic                  btn_meta_q, btn_sync_q, btn_last_q, press_q;

    logic [HEIGHT_W-1:0]   vel_ext;
    logic [7:0]            vel_up, vel_dn;
    logic [HEIGHT_W:0]     fall_sum;

    assign vel_ext  = HEIGHT_W'(vel_q);
    assign vel_up   = vel_q + GravV;
    assign vel_dn   = vel_q - GravV;
    assign fall_sum = {1'b0, height_q} + (HEIGHT_W+1)'(vel_up);

    // Press is registered so it lands one cycle after the synchronized edge.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_last_q <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            btn_meta_q <= jump_btn;
            btn_sync_q <= btn_meta_q;
            btn_last_q <= btn_sync_q;
            press_q    <= btn_sync_q & ~btn_last_q;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= GROUND;
            height_q  <= GroundH;
            vel_q     <= 8'd0;
            dj_used_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            height_q  <= height_d;
            vel_q     <= vel_d;
            dj_used_q <= dj_used_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        height_d  = height_q;
        vel_d     = vel_q;
        dj_used_d = dj_used_q;
        done_d    = 1'b0;

        if (kill) begin
            state_d = state_q;
        end else if (!active) begin
            state_d   = GROUND;
            height_d  = GroundH;
            vel_d     = 8'd0;
            dj_used_d = 1'b0;
        end else begin
            case (state_q)
                GROUND: begin
                    height_d = GroundH;
                    vel_d    = 8'd0;
                    if (press_q) begin
                        state_d = RISE;
                        vel_d   = LaunchV;
                    end
                end
                RISE, FALL: begin
                    // A granted double jump consumes the cycle; any coincident tick is dropped.
                    if (DoubleEn && press_q && !dj_used_q) begin
                        state_d   = RISE;
                        vel_d     = LaunchV;
                        dj_used_d = 1'b1;
                    end else if (frame_tick) begin
                        if (state_q == RISE) begin
                            height_d = (height_q > vel_ext) ? (height_q - vel_ext) : '0;
                            vel_d    = vel_dn;
                            if (vel_dn == 8'd0) begin
                                state_d = FALL;
                            end
                        end else if (fall_sum >= GroundX) begin
                            state_d   = GROUND;
                            height_d  = GroundH;
                            vel_d     = 8'd0;
                            dj_used_d = 1'b0;
                            done_d    = 1'b1;
                        end else begin
                            height_d = fall_sum[HEIGHT_W-1:0];
                            vel_d    = vel_up;
                        end
                    end
                end
                default: begin
                    state_d  = GROUND;
                    height_d = GroundH;
                    vel_d    = 8'd0;
                end
            endcase
        end
    end

    assign height    = height_q;
    assign airborne  = (state_q != GROUND);
    assign jump_done = done_q;

endmodule

// File: tb/tb_dino_jump.sv
// Directed bench for dino_jump: reset, full jump trajectory, kill freeze, abort,
// coincident press/tick, airborne press handling, asynchronous reset mid-jump.
module tb_dino_jump;

    logic        CLOCK_50 = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_tick = 1'b0;
    logic        jump_btn = 1'b0;
    logic        active = 1'b0;
    logic        kill = 1'b0;
    logic [15:0] height;
    logic        airborne;
    logic        jump_done;

    int n_tests = 0;
    int n_fail  = 0;

    dino_jump dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .frame_tick(frame_tick),
        .jump_btn  (jump_btn),
        .active    (active),
        .kill      (kill),
        .height    (height),
        .airborne  (airborne),
        .jump_done (jump_done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    // Button held long enough for one synchronized edge, then released and settled.
    task automatic press_btn();
        jump_btn = 1'b1;
        cyc(5);
        jump_btn = 1'b0;
        cyc(3);
    endtask

    task automatic tick_chk(input string tag, input int exp_h, input bit exp_done);
        tick();
        chk({tag, "_h"}, height, exp_h);
        chk({tag, "_done"}, jump_done, exp_done);
    endtask

    int traj [12] = '{100, 95, 91, 88, 86, 85, 86, 88, 91, 95, 100, 106};

    initial begin
        cyc(2);
        chk("rst_height", height, 106);
        chk("rst_airborne", airborne, 0);
        chk("rst_done", jump_done, 0);
        resetn = 1'b1;
        active = 1'b1;
        cyc(2);

        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_height", height, 106);
        end

        // Launch timing: synchronized edge, registered press, then RISE.
        jump_btn = 1'b1;
        cyc(3);
        chk("launch_not_yet", airborne, 0);
        cyc(1);
        chk("launch_airborne", airborne, 1);
        jump_btn = 1'b0;
        cyc(3);
        chk("launch_hold_h", height, 106);

        for (int i = 0; i < 12; i++) begin
            tick_chk("jump", traj[i], (i == 11));
        end
        chk("land_airborne", airborne, 0);
        cyc(1);
        chk("done_one_cycle", jump_done, 0);

        // Freeze under kill.
        press_btn();
        chk("frz_launch", airborne, 1);
        tick_chk("frz_t1", 100, 0);
        tick_chk("frz_t2", 95, 0);
        tick_chk("frz_t3", 91, 0);
        kill = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        press_btn();
        chk("frz_height", height, 91);
        chk("frz_airborne", airborne, 1);
        kill = 1'b0;
        cyc(1);
        chk("frz_hold_idle", height, 91);
        tick_chk("frz_resume", 88, 0);
        tick_chk("frz_t5", 86, 0);
        tick_chk("frz_apex", 85, 0);

        // Abort at apex.
        active = 1'b0;
        cyc(1);
        chk("abort_height", height, 106);
        chk("abort_airborne", airborne, 0);
        chk("abort_done", jump_done, 0);
        active = 1'b1;
        cyc(2);

        // Press and tick coincide in GROUND: launch only.
        jump_btn = 1'b1;
        cyc(3);
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        jump_btn = 1'b0;
        chk("sim_airborne", airborne, 1);
        chk("sim_height", height, 106);
        tick_chk("sim_t1", 100, 0);
        tick_chk("sim_t2", 95, 0);
        tick_chk("sim_t3", 91, 0);
        tick_chk("sim_t4", 88, 0);
        tick_chk("sim_t5", 86, 0);
        tick_chk("sim_apex", 85, 0);

`ifdef JUMP_DOUBLE_EN
        press_btn();
        chk("dj_height_hold", height, 85);
        chk("dj_airborne", airborne, 1);
        tick_chk("dj_r1", 79, 0);
        tick_chk("dj_r2", 74, 0);
        tick_chk("dj_r3", 70, 0);
        tick_chk("dj_r4", 67, 0);
        tick_chk("dj_r5", 65, 0);
        tick_chk("dj_apex", 64, 0);
        press_btn();
        chk("dj_third_ignored", height, 64);
        tick_chk("dj_f1", 65, 0);
        tick_chk("dj_f2", 67, 0);
        tick_chk("dj_f3", 70, 0);
        tick_chk("dj_f4", 74, 0);
        tick_chk("dj_f5", 79, 0);
        tick_chk("dj_f6", 85, 0);
        tick_chk("dj_f7", 92, 0);
        tick_chk("dj_f8", 100, 0);
        tick_chk("dj_land", 106, 1);
`else
        tick_chk("fall_t1", 86, 0);
        press_btn();
        chk("fall_press_h", height, 86);
        tick_chk("fall_t2", 88, 0);
        tick_chk("fall_t3", 91, 0);
        tick_chk("fall_t4", 95, 0);
        tick_chk("fall_t5", 100, 0);
        tick_chk("fall_land", 106, 1);
`endif
        chk("sim_landed", airborne, 0);

        // Asynchronous reset mid-jump.
        press_btn();
        tick_chk("ar_t1", 100, 0);
        resetn = 1'b0;
        #2;
        chk("ar_height", height, 106);
        chk("ar_airborne", airborne, 0);
        chk("ar_done", jump_done, 0);
        resetn = 1'b1;
        cyc(3);
        tick();
        chk("ar_after", height, 106);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dino_jump.md
# dino_jump

Dino vertical-motion stage for the dinosaur game. It turns jump-button presses into a per-frame vertical position using integer velocity/gravity physics. It sits directly upstream of the VGA renderer and drives its `height` input (top-left y of the 4x4 dino sprite). It also reports airborne status and landing to the game-control FSM.

## Interface

Parameters:
- `GROUND_Y`, default 106: sprite y when standing; reset/idle value of `height`.
- `V0`, default 6: launch velocity, pixels/frame. Must satisfy V0*(V0+1)/2 < GROUND_Y.
- `GRAVITY`, default 1: velocity change per frame. V0 must be a multiple of GRAVITY.
- `HEIGHT_W`, default 16: width of `height`.

Ports:
- `CLOCK_50` in 1: 50 MHz system clock; all state is posedge.
- `resetn` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per video frame (VS falling edge).
- `jump_btn` in 1: jump request, active-high, asynchronous to the clock (inverted KEY).
- `active` in 1: jump physics enabled (FSM `calc_jump`/`ld_game`).
- `kill` in 1: collision flag; freezes motion while high.
- `height` out HEIGHT_W: dino sprite y, screen coordinates, 0 = top.
- `airborne` out 1: high in RISE or FALL.
- `jump_done` out 1: one-cycle pulse on landing.

## Operation

- `jump_btn` passes through a 2-flop synchronizer. A rising edge of the synchronized value is a press (`press`), 1 cycle wide.
- Internal state: `vel` (8-bit unsigned magnitude), `dj_used` (1 bit), FSM {GROUND, RISE, FALL}.
- GROUND: `height` = GROUND_Y and `vel` = 0.
  - `press` with `active`=1 and `kill`=0 → RISE, `vel` = V0.
  - `height` does not change in that cycle.
- RISE, on `frame_tick`:
  - `height` = (`height` > `vel`) ? `height` − `vel` : 0
  - `vel` = `vel` − GRAVITY
  - If the new `vel` = 0 → FALL.
- FALL, on `frame_tick`, with v' = `vel` + GRAVITY:
  - If `height` + v' ≥ GROUND_Y: `height` = GROUND_Y, `vel` = 0, `dj_used` = 0, → GROUND, `jump_done` = 1 for that cycle.
  - Else: `height` = `height` + v', `vel` = v'.
- All additions are done at HEIGHT_W+1 bits; there is no wrap-around.
- A press while airborne is ignored unless the build has JUMP_DOUBLE_EN.
- `kill`=1 overrides everything except reset: state, `height` and `vel` hold; ticks and presses are dropped; `jump_done` = 0.
- `active`=0 (and `kill`=0): synchronous return to GROUND, `height` = GROUND_Y, `vel` = 0, `dj_used` = 0. No `jump_done` pulse. This takes priority over `press` and `frame_tick`.
- `press` and `frame_tick` in the same cycle while in GROUND: only the launch happens. The first position update is on the next `frame_tick`.

## Timing

- Reset values: `height` = GROUND_Y, `airborne` = 0, `jump_done` = 0; FSM in GROUND; `vel` = 0; `dj_used` = 0; synchronizer flops 0.
- Button to launch: `jump_btn` rising → `press` on the 3rd clock edge → `airborne` = 1 one cycle later.
- `height`, `airborne` and `jump_done` are registered. They update on the clock edge that samples `frame_tick`.
- With defaults a jump lasts 12 ticks:
  - Rise: 100, 95, 91, 88, 86, 85 (apex).
  - Fall: 86, 88, 91, 95, 100, 106.
  - `jump_done` pulses on tick 12.
- Reset asserted mid-jump returns all outputs to their reset values immediately (asynchronous).

## Configuration

- `JUMP_DOUBLE_EN` defined:
  - The first `press` while in RISE or FALL with `dj_used` = 0 sets `vel` = V0, `dj_used` = 1, → RISE.
  - `height` is unchanged in that cycle.
  - A second airborne press is ignored.
  - `dj_used` clears on landing or when `active` = 0.
- `JUMP_DOUBLE_EN` undefined: airborne presses are ignored and `dj_used` is constant 0.

## Test plan

- Reset: hold `resetn` = 0 → `height` = 106, `airborne` = 0, `jump_done` = 0. Release and apply 5 ticks with no press → `height` stays 106.
- Single jump: `active` = 1, pulse `jump_btn`, then 12 ticks → `height` sequence 100, 95, 91, 88, 86, 85, 86, 88, 91, 95, 100, 106. `jump_done` is high exactly on tick 12 and `airborne` = 0 after it.
- Freeze: `kill` = 1 after tick 3 (`height` = 91), then 4 ticks and a press → `height` stays 91 and `airborne` stays 1. Release `kill` → the next tick gives 88.
- Abort: `active` = 0 at apex (`height` = 85) → `height` = 106 and `airborne` = 0 on the next cycle, with no `jump_done` pulse.
- Simultaneous events: press and tick in the same cycle from GROUND → `height` stays 106 that tick and the next tick gives 100. A press during FALL without the macro → trajectory unchanged.
- Double jump (JUMP_DOUBLE_EN): press again at `height` = 85 → the next ticks give 79, 74, 70, 67, 65, 64. A third press is ignored, and the dino lands at 106.
